lifo_arbiter: RTL and testbench
===============================

# lifo_arbiter

Round-robin arbiter and sequencer that shares one LIFO stack between `NUM_REQ` requesters. It accepts push/pop requests, issues at most one stack operation per cycle, and tracks stack occupancy in a shadow counter so illegal operations are rejected before they reach the stack. Pop results are returned to the winning requester. The block sits between the client ports and the stack's `push`/`pop`/`data_in`/`data_out` pins.

## Interface
- `NUM_REQ`, 2: number of requesters (2..8).
- `DEPTH`, 16: stack depth in entries; must match the attached stack.
- `DATA_WIDTH`, 16: data word width.
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `req` in NUM_REQ: per-requester request; held until its `gnt` is seen.
- `req_pop` in NUM_REQ: per-requester opcode, 1 = pop, 0 = push; valid with `req`.
- `req_data` in NUM_REQ*DATA_WIDTH: push data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `gnt` out NUM_REQ: one-hot, one-cycle grant pulse.
- `rsp_err` out NUM_REQ: one-cycle pulse with `gnt` when the granted op was rejected (push at full, pop at empty).
- `rsp_valid` out NUM_REQ: one-hot pulse when pop data is on `rsp_data`.
- `rsp_data` out DATA_WIDTH: pop data, equal to `stk_data_out` while any `rsp_valid` bit is set.
- `level` out $clog2(DEPTH+1): shadow occupancy, 0..DEPTH.
- `stk_push` out 1: push strobe to the stack.
- `stk_pop` out 1: pop strobe to the stack.
- `stk_data_in` out DATA_WIDTH: push data to the stack.
- `stk_data_out` in DATA_WIDTH: stack read data, registered by the stack on its pop edge.

## Operation
- Arbitration happens on every rising edge.
  - Candidates: requesters with `req`=1 and `gnt`=0 in the current cycle. A granted requester is masked for the edge that ends its grant cycle.
  - Winner: the first candidate at or after `rr_ptr`, scanning upward with wrap.
  - After any grant (legal or rejected), `rr_ptr` becomes winner+1 mod NUM_REQ.
  - No candidates: no grant, `rr_ptr` unchanged.
- Legality is decided at the arbitration edge using the current `level`.
  - Push is legal if `level` < DEPTH.
  - Pop is legal if `level` > 0.
- Legal op:
  - `level` updates at the arbitration edge: +1 for push, -1 for pop.
  - `stk_push` or `stk_pop` is registered high for exactly one cycle.
  - For a push, `stk_data_in` is registered from the winner's `req_data` slice.
- Rejected op:
  - `gnt` and `rsp_err` pulse for the winner.
  - No stack strobe, no `level` change, no `rsp_valid`.
- Pop response: the winner index is carried for one more cycle, then its `rsp_valid` bit pulses.
- `stk_push` and `stk_pop` are never high together. The stack never sees push-at-full or pop-at-empty.
- Reset (`rst_n`=0, asynchronous, including mid-operation):
  - all outputs 0: `gnt`, `rsp_err`, `rsp_valid`, `stk_push`, `stk_pop`, `stk_data_in`, `level`;
  - `rr_ptr`=0;
  - any in-flight pop response is dropped.
  - The stack must be reset in the same reset event so that `level`=0 matches an empty stack.

## Timing
- Edge E0 samples `req`.
- Cycle C1 (after E0): `gnt`, `rsp_err`, and `stk_push`/`stk_pop`/`stk_data_in` are high.
- Edge E1: the stack executes the op.
- Cycle C2: for a pop, `rsp_valid` is high and `rsp_data` = `stk_data_out`.
- Latency from request to grant is 1 cycle. Latency from request to pop data is 2 cycles.
- Throughput is 1 op per cycle when requesters alternate. A single continuous requester gets one grant every 2 cycles, because of masking.
- A requester must drop or change `req` in the cycle after `gnt`. A `req` still high then is a new request.
- `level` is registered. It already reflects ops granted at the previous edge, so back-to-back ops near full/empty are decided correctly.

## Test plan
- Reset with `req`=2'b11 held → all outputs 0 during reset. The first grant after release goes to requester 0, then requester 1, then 0 (round-robin).
- Requester 0 pushes 0x1111, 0x2222, 0x3333, then pops three times → `rsp_data` 0x3333, 0x2222, 0x1111, each `rsp_valid`[0] 2 cycles after its request. `level` goes 3 → 0.
- Push DEPTH words, then push 0xBEEF → `gnt`+`rsp_err` pulse, no `stk_push`, `level`=16 held. Pop → 0x000F (the last value pushed).
- Pop at `level`=0 → `rsp_err` pulse, no `stk_pop`, no `rsp_valid`.
- Requester 0 push 0xAAAA and requester 1 pop in the same cycle with `level`=1 (top 0x5555), `rr_ptr`=1 → requester 1 pops 0x5555, then requester 0 pushes. Final `level`=1 with 0xAAAA on top.
- Assert `rst_n`=0 in C1 of a pop → `rsp_valid` never asserts, `level`=0, `rr_ptr`=0.

Source files
------------

// File: rtl/lifo_arbiter_if.sv
// -----------------------------------------------------------------------------
// lifo_arbiter_if
// Client-side bundle for the shared LIFO arbiter.
//
// Signals
//   req        [NUM_REQ]            per-requester request, held until gnt seen
//   req_pop    [NUM_REQ]            opcode per requester: 1 = pop, 0 = push
//   req_data   [NUM_REQ*DATA_WIDTH] push data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt        [NUM_REQ]            one-hot single-cycle grant pulse
//   rsp_err    [NUM_REQ]            pulses with gnt when the granted op was rejected
//   rsp_valid  [NUM_REQ]            one-hot pulse when pop data is on rsp_data
//   rsp_data   [DATA_WIDTH]         pop data returned to the requester
//
// Modports
//   master : the requesters (drive req*, observe responses)
//   slave  : the arbiter    (observe req*, drive responses)
// -----------------------------------------------------------------------------
interface lifo_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 16
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            req_pop;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            rsp_err;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_data;

    modport master (
        output req,
        output req_pop,
        output req_data,
        input  gnt,
        input  rsp_err,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req,
        input  req_pop,
        input  req_data,
        output gnt,
        output rsp_err,
        output rsp_valid,
        output rsp_data
    );
endinterface : lifo_arbiter_if

// File: rtl/lifo_arbiter.sv
// -----------------------------------------------------------------------------
// lifo_arbiter
// Round-robin arbiter / sequencer sharing one LIFO stack between NUM_REQ
// requesters. At most one stack operation is issued per cycle. A shadow
// occupancy counter (level) lets the arbiter reject push-at-full and
// pop-at-empty before they ever reach the stack. Pop data is returned to the
// requester that won the pop.
//
// Ports
//   clk           clock, all logic on the rising edge
//   rst_n         asynchronous active-low reset (stack must share it)
//   cli           client bundle (lifo_arbiter_if.slave)
//   level         shadow occupancy 0..DEPTH
//   stk_push      one-cycle push strobe to the stack
//   stk_pop       one-cycle pop strobe to the stack
//   stk_data_in   push data to the stack
//   stk_data_out  stack read data, registered by the stack on its pop edge
//
// Timing
//   E0 samples req -> C1: gnt / rsp_err / stack strobe -> E1: stack executes
//   -> C2: rsp_valid with rsp_data = stk_data_out (pops only).
// -----------------------------------------------------------------------------
module lifo_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    lifo_arbiter_if.slave                cli,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         stk_push,
    output logic                         stk_pop,
    output logic [DATA_WIDTH-1:0]        stk_data_in,
    input  logic [DATA_WIDTH-1:0]        stk_data_out
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LEVEL_ONE  = LW'(1);

    // -------------------------------------------------------------------------
    // Registered state
    // -------------------------------------------------------------------------
    logic [NUM_REQ-1:0]    gnt_q,         gnt_d;
    logic [NUM_REQ-1:0]    rsp_err_q,     rsp_err_d;
    logic [NUM_REQ-1:0]    rsp_valid_q,   rsp_valid_d;
    logic                  stk_push_q,    stk_push_d;
    logic                  stk_pop_q,     stk_pop_d;
    logic [DATA_WIDTH-1:0] stk_data_in_q, stk_data_in_d;
    logic [LW-1:0]         level_q,       level_d;
    logic [PW-1:0]         rr_ptr_q,      rr_ptr_d;
    // Winner of the pop currently on stk_pop; routes rsp_valid one cycle later.
    logic [PW-1:0]         pop_idx_q,     pop_idx_d;

    // -------------------------------------------------------------------------
    // Per-requester data slices
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] req_data_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
        assign req_data_arr[gi] = cli.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // -------------------------------------------------------------------------
    // Candidate selection
    // A requester whose grant is visible this cycle is masked, so a request
    // still held during its grant cycle is not granted twice.
    // -------------------------------------------------------------------------
    logic [NUM_REQ-1:0] cand;

    assign cand = cli.req & ~gnt_q;

    // (base + off) mod NUM_REQ for off in 0..NUM_REQ; NUM_REQ need not be a
    // power of two, so the wrap is explicit.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base,
                                               input logic [31:0]   off);
        logic [31:0] s;
        s = 32'(base) + off;
        if (s >= 32'(NUM_REQ)) begin
            s = s - 32'(NUM_REQ);
        end
        return s[PW-1:0];
    endfunction

    // -------------------------------------------------------------------------
    // Round-robin winner: first candidate at or after rr_ptr, scanning upward
    // -------------------------------------------------------------------------
    logic          found;
    logic [PW-1:0] win_idx;
    logic [PW-1:0] scan_idx;

    always_comb begin
        found    = 1'b0;
        win_idx  = '0;
        scan_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = wrap_add(rr_ptr_q, 32'(k));
            if (!found && cand[scan_idx]) begin
                found   = 1'b1;
                win_idx = scan_idx;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Legality against the registered shadow level. level_q already includes
    // the op granted on the previous edge, so back-to-back ops at the
    // boundaries are judged correctly.
    // -------------------------------------------------------------------------
    logic win_pop;
    logic push_ok;
    logic pop_ok;
    logic legal;

    always_comb begin
        win_pop = cli.req_pop[win_idx];
        push_ok = (level_q != LEVEL_FULL);
        pop_ok  = (level_q != '0);
        legal   = win_pop ? pop_ok : push_ok;
    end

    // -------------------------------------------------------------------------
    // Next-state / output decode
    // -------------------------------------------------------------------------
    always_comb begin
        gnt_d         = '0;
        rsp_err_d     = '0;
        rsp_valid_d   = '0;
        stk_push_d    = 1'b0;
        stk_pop_d     = 1'b0;
        stk_data_in_d = '0;
        level_d       = level_q;
        rr_ptr_d      = rr_ptr_q;
        pop_idx_d     = pop_idx_q;

        if (found) begin
            gnt_d[win_idx] = 1'b1;
            // Pointer advances on every grant, legal or rejected.
            rr_ptr_d       = wrap_add(win_idx, 32'd1);
            if (!legal) begin
                rsp_err_d[win_idx] = 1'b1;
            end else if (win_pop) begin
                stk_pop_d = 1'b1;
                level_d   = level_q - LEVEL_ONE;
                pop_idx_d = win_idx;
            end else begin
                stk_push_d    = 1'b1;
                stk_data_in_d = req_data_arr[win_idx];
                level_d       = level_q + LEVEL_ONE;
            end
        end

        // The stack registers its read data on the edge that ends the pop
        // strobe cycle, so the response is flagged the cycle after stk_pop.
        if (stk_pop_q) begin
            rsp_valid_d[pop_idx_q] = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // State registers. Reset drops any in-flight pop response because
    // stk_pop_q is cleared together with everything else.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q         <= '0;
            rsp_err_q     <= '0;
            rsp_valid_q   <= '0;
            stk_push_q    <= 1'b0;
            stk_pop_q     <= 1'b0;
            stk_data_in_q <= '0;
            level_q       <= '0;
            rr_ptr_q      <= '0;
            pop_idx_q     <= '0;
        end else begin
            gnt_q         <= gnt_d;
            rsp_err_q     <= rsp_err_d;
            rsp_valid_q   <= rsp_valid_d;
            stk_push_q    <= stk_push_d;
            stk_pop_q     <= stk_pop_d;
            stk_data_in_q <= stk_data_in_d;
            level_q       <= level_d;
            rr_ptr_q      <= rr_ptr_d;
            pop_idx_q     <= pop_idx_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign cli.gnt       = gnt_q;
    assign cli.rsp_err   = rsp_err_q;
    assign cli.rsp_valid = rsp_valid_q;
    assign cli.rsp_data  = (|rsp_valid_q) ? stk_data_out : '0;

    assign level       = level_q;
    assign stk_push    = stk_push_q;
    assign stk_pop     = stk_pop_q;
    assign stk_data_in = stk_data_in_q;

    // Only one op is issued per edge, so the two strobes are exclusive.
    a_strobe_exclusive : assert property (
        @(posedge clk) disable iff (!rst_n) !(stk_push_q && stk_pop_q)
    );

endmodule : lifo_arbiter

// File: tb/tb_lifo_arbiter.sv
// -----------------------------------------------------------------------------
// tb_lifo_arbiter
// Directed bench for lifo_arbiter with a small behavioural stack attached.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_lifo_arbiter;

    localparam int NR    = 2;
    localparam int DEPTH = 16;
    localparam int DW    = 16;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [LW-1:0] level;
    logic          stk_push;
    logic          stk_pop;
    logic [DW-1:0] stk_data_in;
    logic [DW-1:0] stk_data_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lifo_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) cli ();

    lifo_arbiter #(
        .NUM_REQ    (NR),
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cli          (cli),
        .level        (level),
        .stk_push     (stk_push),
        .stk_pop      (stk_pop),
        .stk_data_in  (stk_data_in),
        .stk_data_out (stk_data_out)
    );

    // Behavioural LIFO sharing the arbiter's reset.
    logic [DW-1:0] stk_mem [DEPTH];
    int            stk_sp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stk_sp       <= 0;
            stk_data_out <= '0;
        end else if (stk_push && stk_sp < DEPTH) begin
            stk_mem[stk_sp] <= stk_data_in;
            stk_sp          <= stk_sp + 1;
        end else if (stk_pop && stk_sp > 0) begin
            stk_data_out <= stk_mem[stk_sp-1];
            stk_sp       <= stk_sp - 1;
        end
    end

    // Stimulus only: single requester op from request to C2.
    task automatic run_op(input int r, input logic pop, input logic [DW-1:0] d,
                          output logic [NR-1:0] g, output logic [NR-1:0] e,
                          output logic sp, output logic spo, output logic [DW-1:0] sdi,
                          output logic [NR-1:0] rv, output logic [DW-1:0] rd,
                          output logic [LW-1:0] lv);
        cli.req[r]               = 1'b1;
        cli.req_pop[r]           = pop;
        cli.req_data[r*DW +: DW] = d;
        @(negedge clk);
        g   = cli.gnt;
        e   = cli.rsp_err;
        sp  = stk_push;
        spo = stk_pop;
        sdi = stk_data_in;
        cli.req[r] = 1'b0;
        @(negedge clk);
        rv = cli.rsp_valid;
        rd = cli.rsp_data;
        lv = level;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        cli.req      = '0;
        cli.req_pop  = '0;
        cli.req_data = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        cli.req      = 2'b11;
        cli.req_pop  = 2'b00;
        cli.req_data = {16'h0B0B, 16'h0A0A};
        repeat (3) @(negedge clk);
        checks++;
        if ({cli.gnt, cli.rsp_err, cli.rsp_valid} !== 6'b0) begin
            errors++;
            $display("FAIL reset_rsp: gnt/err/valid=%b expected 000000", {cli.gnt, cli.rsp_err, cli.rsp_valid});
        end
        checks++;
        if ({stk_push, stk_pop, stk_data_in, level} !== '0) begin
            errors++;
            $display("FAIL reset_stk: push=%b pop=%b din=%h level=%0d expected all 0", stk_push, stk_pop, stk_data_in, level);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cli.gnt !== 2'b01 || stk_data_in !== 16'h0A0A) begin
            errors++;
            $display("FAIL rr_first: gnt=%b din=%h expected 01/0a0a", cli.gnt, stk_data_in);
        end
        @(negedge clk);
        checks++;
        if (cli.gnt !== 2'b10 || stk_data_in !== 16'h0B0B) begin
            errors++;
            $display("FAIL rr_second: gnt=%b din=%h expected 10/0b0b", cli.gnt, stk_data_in);
        end
        @(negedge clk);
        checks++;
        if (cli.gnt !== 2'b01 || level !== LW'(3)) begin
            errors++;
            $display("FAIL rr_third: gnt=%b level=%0d expected 01/3", cli.gnt, level);
        end
        cli.req = '0;
        @(negedge clk);
    endtask

    task automatic test_lifo_order();
        logic [DW-1:0] vals [3];
        logic [NR-1:0] g, e, rv;
        logic          sp, spo;
        logic [DW-1:0] sdi, rd;
        logic [LW-1:0] lv;
        vals[0] = 16'h1111;
        vals[1] = 16'h2222;
        vals[2] = 16'h3333;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            run_op(0, 1'b0, vals[i], g, e, sp, spo, sdi, rv, rd, lv);
            checks++;
            if (g !== 2'b01 || e !== 2'b00 || sp !== 1'b1 || sdi !== vals[i] || lv !== LW'(i+1)) begin
                errors++;
                $display("FAIL lifo_push%0d: gnt=%b err=%b push=%b din=%h level=%0d expected 01/00/1/%h/%0d",
                         i, g, e, sp, sdi, lv, vals[i], i+1);
            end
        end
        for (int i = 0; i < 3; i++) begin
            run_op(0, 1'b1, 16'h0, g, e, sp, spo, sdi, rv, rd, lv);
            checks++;
            if (g !== 2'b01 || spo !== 1'b1 || rv !== 2'b01 || rd !== vals[2-i] || lv !== LW'(2-i)) begin
                errors++;
                $display("FAIL lifo_pop%0d: gnt=%b pop=%b valid=%b data=%h level=%0d expected 01/1/01/%h/%0d",
                         i, g, spo, rv, rd, lv, vals[2-i], 2-i);
            end
        end
    endtask

    task automatic test_full();
        logic [NR-1:0] g, e, rv;
        logic          sp, spo;
        logic [DW-1:0] sdi, rd;
        logic [LW-1:0] lv;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            run_op(0, 1'b0, DW'(i), g, e, sp, spo, sdi, rv, rd, lv);
        end
        checks++;
        if (lv !== LW'(DEPTH)) begin
            errors++;
            $display("FAIL full_level: level=%0d expected %0d", lv, DEPTH);
        end
        run_op(0, 1'b0, 16'hBEEF, g, e, sp, spo, sdi, rv, rd, lv);
        checks++;
        if (g !== 2'b01 || e !== 2'b01 || sp !== 1'b0 || lv !== LW'(DEPTH)) begin
            errors++;
            $display("FAIL full_reject: gnt=%b err=%b push=%b level=%0d expected 01/01/0/%0d", g, e, sp, lv, DEPTH);
        end
        run_op(0, 1'b1, 16'h0, g, e, sp, spo, sdi, rv, rd, lv);
        checks++;
        if (rv !== 2'b01 || rd !== 16'h000F || lv !== LW'(DEPTH-1)) begin
            errors++;
            $display("FAIL full_pop: valid=%b data=%h level=%0d expected 01/000f/%0d", rv, rd, lv, DEPTH-1);
        end
    endtask

    task automatic test_empty();
        logic [NR-1:0] g, e, rv;
        logic          sp, spo;
        logic [DW-1:0] sdi, rd;
        logic [LW-1:0] lv;
        do_reset();
        run_op(1, 1'b1, 16'h0, g, e, sp, spo, sdi, rv, rd, lv);
        checks++;
        if (g !== 2'b10 || e !== 2'b10 || spo !== 1'b0 || rv !== 2'b00 || lv !== LW'(0)) begin
            errors++;
            $display("FAIL empty_reject: gnt=%b err=%b pop=%b valid=%b level=%0d expected 10/10/0/00/0", g, e, spo, rv, lv);
        end
    endtask

    task automatic test_back_to_back();
        logic [NR-1:0] g, e, rv;
        logic          sp, spo;
        logic [DW-1:0] sdi, rd;
        logic [LW-1:0] lv;
        do_reset();
        // Push by requester 0 leaves rr_ptr at 1.
        run_op(0, 1'b0, 16'h5555, g, e, sp, spo, sdi, rv, rd, lv);
        cli.req                = 2'b11;
        cli.req_pop            = 2'b10;
        cli.req_data[0 +: DW]  = 16'hAAAA;
        @(negedge clk);
        checks++;
        if (cli.gnt !== 2'b10 || stk_pop !== 1'b1 || stk_push !== 1'b0) begin
            errors++;
            $display("FAIL b2b_c1: gnt=%b pop=%b push=%b expected 10/1/0", cli.gnt, stk_pop, stk_push);
        end
        cli.req[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (cli.gnt !== 2'b01 || stk_push !== 1'b1 || stk_data_in !== 16'hAAAA ||
            cli.rsp_valid !== 2'b10 || cli.rsp_data !== 16'h5555) begin
            errors++;
            $display("FAIL b2b_c2: gnt=%b push=%b din=%h valid=%b data=%h expected 01/1/aaaa/10/5555",
                     cli.gnt, stk_push, stk_data_in, cli.rsp_valid, cli.rsp_data);
        end
        cli.req[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (level !== LW'(1)) begin
            errors++;
            $display("FAIL b2b_level: level=%0d expected 1", level);
        end
        run_op(0, 1'b1, 16'h0, g, e, sp, spo, sdi, rv, rd, lv);
        checks++;
        if (rv !== 2'b01 || rd !== 16'hAAAA) begin
            errors++;
            $display("FAIL b2b_top: valid=%b data=%h expected 01/aaaa", rv, rd);
        end
    endtask

    task automatic test_reset_midpop();
        logic [NR-1:0] g, e, rv;
        logic          sp, spo;
        logic [DW-1:0] sdi, rd;
        logic [LW-1:0] lv;
        logic          rv_seen;
        do_reset();
        run_op(0, 1'b0, 16'h1234, g, e, sp, spo, sdi, rv, rd, lv);
        cli.req[0]     = 1'b1;
        cli.req_pop[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (stk_pop !== 1'b1) begin
            errors++;
            $display("FAIL midpop_c1: pop=%b expected 1", stk_pop);
        end
        #1;
        rst_n   = 1'b0;
        cli.req = '0;
        #1;
        checks++;
        if (stk_pop !== 1'b0 || cli.gnt !== 2'b00) begin
            errors++;
            $display("FAIL midpop_async: pop=%b gnt=%b expected 0/00", stk_pop, cli.gnt);
        end
        rv_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (cli.rsp_valid !== 2'b00) rv_seen = 1'b1;
        end
        checks++;
        if (rv_seen !== 1'b0 || level !== LW'(0)) begin
            errors++;
            $display("FAIL midpop_drop: valid_seen=%b level=%0d expected 0/0", rv_seen, level);
        end
        // Before reset rr_ptr was 1; after reset requester 0 must win.
        cli.req     = 2'b11;
        cli.req_pop = 2'b00;
        rst_n       = 1'b1;
        @(negedge clk);
        checks++;
        if (cli.gnt !== 2'b01) begin
            errors++;
            $display("FAIL midpop_rrptr: gnt=%b expected 01", cli.gnt);
        end
        cli.req = '0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_lifo_order();
        test_full();
        test_empty();
        test_back_to_back();
        test_reset_midpop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_lifo_arbiter
